// File: rtl/window3x3_filter.sv
`default_nettype none
// ============================================================================
//  Module      : window3x3_filter
//  Description : 3x3 neighbourhood filter for the camera write path. Two line
//                buffers and a 3x3 window register build the neighbourhood of
//                the pixel one line and one column behind the input. One
//                filtered pixel is produced per accepted input pixel, two
//                cycles after the input is accepted.
//                Modes: 0 pass, 1 grey, 2 Sobel magnitude, 3 box blur.
//  Ports       : CLK, RESET_N (async, active low)
//                iMODE  [1:0]   filter mode, latched on an iSOF beat
//                iVALID, iSOF   input beat qualifier / start of frame
//                iPIXEL [3CW]   {R,G,B}, B in the LSBs
//                oVALID, oSOF   output beat qualifier / window centre (0,0)
//                oPIXEL [3CW]   filtered pixel, held while oVALID is low
//  Revision    : 1.0 - initial release
// ============================================================================
module window3x3_filter #(
   parameter int CW           = 10,
   parameter int LINE_WIDTH   = 800,
   parameter int FRAME_HEIGHT = 480
) (
   input  logic            CLK,
   input  logic            RESET_N,
   input  logic [1:0]      iMODE,
   input  logic            iVALID,
   input  logic            iSOF,
   input  logic [3*CW-1:0] iPIXEL,
   output logic            oVALID,
   output logic            oSOF,
   output logic [3*CW-1:0] oPIXEL
);
   localparam int PW   = 3 * CW;
   localparam int COLW = $clog2(LINE_WIDTH);
   localparam int ROWW = $clog2(FRAME_HEIGHT);
   localparam logic [COLW-1:0] COL_LAST = COLW'(LINE_WIDTH - 1);
   localparam logic [ROWW-1:0] ROW_LAST = ROWW'(FRAME_HEIGHT - 1);
   localparam logic [1:0] MODE_PASS  = 2'd0;
   localparam logic [1:0] MODE_GREY  = 2'd1;
   localparam logic [1:0] MODE_SOBEL = 2'd2;

   function automatic logic [CW-1:0] grey(input logic [PW-1:0] p);
      logic [CW+1:0] s;
      s = {2'b00, p[3*CW-1:2*CW]} + {2'b00, p[2*CW-1:CW]} + {2'b00, p[CW-1:0]};
      return CW'(s / (CW+2)'(3));
   endfunction

   // 1-2-1 weighted column/row of the Sobel kernel
   function automatic logic [CW+1:0] tap3(input logic [CW-1:0] a, b, c);
      return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
   endfunction

   function automatic logic [CW+1:0] absdiff(input logic [CW+1:0] a, b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   // ---------------- position counters and mode ----------------
   logic [COLW-1:0] col_q, col_d, cur_col;
   logic [ROWW-1:0] row_q, row_d, cur_row;
   logic [1:0]      mode_q, mode_d, cur_mode;
   logic            beat_border, beat_sof;

   always_comb begin
      cur_col  = iSOF ? '0 : col_q;
      cur_row  = iSOF ? '0 : row_q;
      cur_mode = iSOF ? iMODE : mode_q;
      col_d    = col_q;
      row_d    = row_q;
      mode_d   = mode_q;
      if (iVALID) begin
         mode_d = cur_mode;
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROWW'(1);
         end else begin
            col_d = cur_col + COLW'(1);
            row_d = cur_row;
         end
      end
      // Centre is (row-1, col-1), or (row-2, LINE_WIDTH-1) when col is 0.
      // Rows 0/1 cover centres in the previous frame and centre row 0;
      // cols 0/1 cover centre cols LINE_WIDTH-1 and 0. Centre row
      // FRAME_HEIGHT-1 is only reached by the next frame's row 0.
      beat_border = (cur_row == '0) || (cur_row == ROWW'(1)) ||
                    (cur_col == '0) || (cur_col == COLW'(1));
      beat_sof    = (cur_row == ROWW'(1)) && (cur_col == COLW'(1));
   end

   // ---------------- line buffers (one 2-line shift chain) ----------------
   // lb_q[k] holds the pixel accepted k+1 beats ago.
   logic [PW-1:0] lb_q [2*LINE_WIDTH];
   logic [PW-1:0] lb_d [2*LINE_WIDTH];

   always_comb begin
      lb_d = lb_q;
      if (iVALID) begin
         lb_d[0] = iPIXEL;
         for (int i = 1; i < 2*LINE_WIDTH; i++) lb_d[i] = lb_q[i-1];
      end
   end

   always_ff @(posedge CLK) lb_q <= lb_d;

   // ---------------- window stage: P1..P9 = win[0..8] ----------------
   logic [PW-1:0] win_q [9];
   logic [PW-1:0] win_d [9];
   logic          wv_q, wv_d, wb_q, wb_d, ws_q, ws_d;
   logic [1:0]    wm_q, wm_d;

   always_comb begin
      win_d = win_q;
      wv_d  = iVALID;
      wb_d  = wb_q;
      ws_d  = ws_q;
      wm_d  = wm_q;
      if (iVALID) begin
         win_d[0] = win_q[1];  win_d[1] = win_q[2];  win_d[2] = lb_q[2*LINE_WIDTH-1];
         win_d[3] = win_q[4];  win_d[4] = win_q[5];  win_d[5] = lb_q[LINE_WIDTH-1];
         win_d[6] = win_q[7];  win_d[7] = win_q[8];  win_d[8] = iPIXEL;
         wb_d = beat_border;
         ws_d = beat_sof;
         wm_d = cur_mode;
      end
   end

   // ---------------- stage 1: grey values and channel sums ----------------
   logic [CW+3:0] win_sum [3];
   logic [CW-1:0] s1_g_q [9];
   logic [CW-1:0] s1_g_d [9];
   logic [CW+3:0] s1_sum_q [3];
   logic [CW+3:0] s1_sum_d [3];
   logic [PW-1:0] s1_c_q, s1_c_d;
   logic          s1_v_q, s1_v_d, s1_b_q, s1_b_d, s1_s_q, s1_s_d;
   logic [1:0]    s1_m_q, s1_m_d;

   always_comb begin
      for (int ch = 0; ch < 3; ch++) begin
         win_sum[ch] = '0;
         for (int i = 0; i < 9; i++)
            win_sum[ch] = win_sum[ch] + (CW+4)'(win_q[i][ch*CW +: CW]);
      end
      s1_v_d   = wv_q;
      s1_g_d   = s1_g_q;
      s1_sum_d = s1_sum_q;
      s1_c_d   = s1_c_q;
      s1_b_d   = s1_b_q;
      s1_s_d   = s1_s_q;
      s1_m_d   = s1_m_q;
      if (wv_q) begin
         for (int i = 0; i < 9; i++) s1_g_d[i] = grey(win_q[i]);
         s1_sum_d = win_sum;
         s1_c_d   = win_q[4];
         s1_b_d   = wb_q;
         s1_s_d   = ws_q;
         s1_m_d   = wm_q;
      end
   end

   // ---------------- stage 2: mode select into output register ----------------
   logic [CW+1:0] gx_p, gx_n, gy_p, gy_n;
   logic [CW+2:0] mag;
   logic [CW-1:0] sob;
   logic [CW-1:0] blur [3];
   logic          ovalid_q, ovalid_d, osof_q, osof_d;
   logic [PW-1:0] opixel_q, opixel_d;

   always_comb begin
      gx_p = tap3(s1_g_q[2], s1_g_q[5], s1_g_q[8]);
      gx_n = tap3(s1_g_q[0], s1_g_q[3], s1_g_q[6]);
      gy_p = tap3(s1_g_q[6], s1_g_q[7], s1_g_q[8]);
      gy_n = tap3(s1_g_q[0], s1_g_q[1], s1_g_q[2]);
      mag  = {1'b0, absdiff(gx_p, gx_n)} + {1'b0, absdiff(gy_p, gy_n)};
      sob  = (mag[CW+2:CW] != 3'b000) ? {CW{1'b1}} : mag[CW-1:0];
      for (int ch = 0; ch < 3; ch++) blur[ch] = CW'(s1_sum_q[ch] / (CW+4)'(9));
      ovalid_d = s1_v_q;
      osof_d   = s1_v_q & s1_s_q;
      opixel_d = opixel_q;
      if (s1_v_q) begin
         case (s1_m_q)
            MODE_PASS:  opixel_d = s1_c_q;
            MODE_GREY:  opixel_d = {3{s1_g_q[4]}};
            MODE_SOBEL: opixel_d = {3{sob}};
            default:    opixel_d = {blur[2], blur[1], blur[0]};
         endcase
         if (s1_b_q && (s1_m_q != MODE_PASS)) opixel_d = '0;
      end
   end

   // ---------------- state registers ----------------
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         col_q    <= '0;
         row_q    <= '0;
         mode_q   <= MODE_PASS;
         win_q    <= '{default: '0};
         wv_q     <= 1'b0;
         wb_q     <= 1'b0;
         ws_q     <= 1'b0;
         wm_q     <= MODE_PASS;
         s1_g_q   <= '{default: '0};
         s1_sum_q <= '{default: '0};
         s1_c_q   <= '0;
         s1_v_q   <= 1'b0;
         s1_b_q   <= 1'b0;
         s1_s_q   <= 1'b0;
         s1_m_q   <= MODE_PASS;
         ovalid_q <= 1'b0;
         osof_q   <= 1'b0;
         opixel_q <= '0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         mode_q   <= mode_d;
         win_q    <= win_d;
         wv_q     <= wv_d;
         wb_q     <= wb_d;
         ws_q     <= ws_d;
         wm_q     <= wm_d;
         s1_g_q   <= s1_g_d;
         s1_sum_q <= s1_sum_d;
         s1_c_q   <= s1_c_d;
         s1_v_q   <= s1_v_d;
         s1_b_q   <= s1_b_d;
         s1_s_q   <= s1_s_d;
         s1_m_q   <= s1_m_d;
         ovalid_q <= ovalid_d;
         osof_q   <= osof_d;
         opixel_q <= opixel_d;
      end
   end

   assign oVALID = ovalid_q;
   assign oSOF   = osof_q;
   assign oPIXEL = opixel_q;

endmodule
`default_nettype wire

// File: doc/window3x3_filter.md
# window3x3_filter

Parametrised 3×3 neighbourhood filter for the camera write path. It sits between the CCD pixel stream and the CCD FIFO in the SRAM controller. It generalises the fixed Sobel-only path to four runtime modes, a configurable channel width, and a configurable frame geometry. Two internal line buffers build a 3×3 window and emit one filtered pixel per accepted input pixel through a fixed 2-cycle pipeline.

## Interface
- CW, default 10: bits per colour channel; a pixel is 3·CW bits, packed as {R,G,B}, with B in the LSBs.
- LINE_WIDTH, default 800: pixels per line. Must be ≥ 3.
- FRAME_HEIGHT, default 480: lines per frame. Must be ≥ 3.

- CLK  in  1  single clock for all logic.
- RESET_N  in  1  asynchronous active-low reset.
- iMODE  in  2  filter mode: 0 pass, 1 grey, 2 Sobel, 3 box blur.
- iVALID  in  1  input pixel valid. No backpressure; every valid beat is consumed.
- iSOF  in  1  start of frame. Qualified by iVALID and marks pixel (0,0).
- iPIXEL  in  3·CW  input pixel.
- oVALID  out  1  output pixel valid.
- oSOF  out  1  marks the output whose window centre is (0,0).
- oPIXEL  out  3·CW  filtered pixel.

## Operation
- Column counter: 0..LINE_WIDTH-1, wraps to 0. On wrap the row counter increments.
- Row counter: 0..FRAME_HEIGHT-1, wraps to 0 with no iSOF required (implicit frame).
- iSOF with iVALID forces col=row=0 for that beat. iSOF without iVALID is ignored.
- Mode register: latched from iMODE only on an iSOF beat, so the mode is constant within a frame. Its reset value is 0 (pass).
- Line buffers: two LINE_WIDTH-deep shift buffers hold the previous two lines. A 3×3 window register P1..P9 holds them, with P9 the newest pixel.
- Window centre: input at (r,c) yields the window centred on (r-1,c-1). When c=0, the centre is (r-2, LINE_WIDTH-1) of the same frame.
- Border centres (row 0, row FRAME_HEIGHT-1, col 0, col LINE_WIDTH-1):
  - modes 1–3 output all zeros;
  - mode 0 outputs the centre pixel unchanged.
- Frame edges:
  - The first LINE_WIDTH+1 beats of a frame produce outputs whose centre lies in the previous frame. These are flagged as border and output zeros (pass mode: stale centre).
  - The final LINE_WIDTH+1 centres of a frame are never emitted.
  - Stale line-buffer contents therefore never reach a non-border output after an iSOF.
- Mode 0, pass: oPIXEL = centre pixel P5.
- Mode 1, grey: g = floor((R+G+B)/3) of P5, using a CW+2-bit sum. Output is {g,g,g}.
- Mode 2, Sobel: computed on the grey value of each of the 9 pixels.
  - Gx = (P3+2P6+P9) − (P1+2P4+P7).
  - Gy = (P7+2P8+P9) − (P1+2P2+P3).
  - Each is signed, CW+3 bits.
  - m = |Gx|+|Gy|, saturated to 2^CW−1. Output is {m,m,m}.
- Mode 3, blur: per channel, floor(sum of 9 / 9), using a CW+4-bit sum. No saturation is needed.
- All division is truncating and unsigned.

## Timing
- Latency is fixed: a pixel accepted at rising edge k produces oVALID=1 during the cycle after edge k+2.
- oVALID replicates the iVALID pattern delayed by 2 cycles; gaps propagate unchanged.
- oSOF is high for exactly one oVALID beat per frame, the beat whose centre is (0,0). That centre is reached when input (1,1) is accepted.
- oPIXEL is don't-care while oVALID=0, but holds its last value; the bench may check that it is stable.
- Reset values: oVALID=0, oSOF=0, oPIXEL=0, counters=0, mode=0. The window and pipeline registers clear to 0. Line-buffer contents are undefined.
- Reset asserted mid-frame: outputs drop to reset values immediately (asynchronous). In-flight beats are discarded. The first post-reset pixel is treated as (0,0) even without iSOF.
- iSOF arriving mid-line or mid-frame: counters restart on that beat. Beats already in the pipeline still emerge, with their original border flags.
- Throughput: one pixel per cycle sustained, with iVALID held high indefinitely.

## Test plan
- Pass, with CW=10, LINE_WIDTH=4, FRAME_HEIGHT=3, a ramp iPIXEL=beat index, and iVALID held high:
  - oVALID rises 2 cycles after the first beat.
  - The output stream equals the input delayed by 5 beats.
  - oSOF coincides with the output for input index 5.
- Grey: a flat frame of R=300, G=301, B=302 in mode 1 gives interior outputs {301,301,301} and border outputs 0.
- Sobel saturation: a frame with columns 0–1 at 0 and columns 2–3 at 1023 on all channels, in mode 2:
  - The interior column-1 centre gives |Gx| = 4092, saturated to 1023, so the output is {1023,1023,1023}.
  - A flat frame gives 0.
- Blur: a frame of constant 500 gives interior outputs of 500. Setting one pixel inside the window to 509 gives floor(4509/9) = 501.
- Mode latch:
  - Changing iMODE from 0 to 2 mid-frame has no effect until the next iSOF beat.
  - The output after that iSOF applies Sobel with 2-cycle latency.
- Reset and resync:
  - Assert RESET_N=0 mid-line and check that oVALID, oSOF and oPIXEL go to 0 before the next edge.
  - Next, issue an iSOF after 2 beats into a line and check that border zeros appear for the next LINE_WIDTH+1 outputs.
  - Finally, drive random iVALID gaps and confirm the 2-cycle latency is preserved beat for beat.
